// File: rtl/banco_scanner_if.sv
// Debug-side control, banco read/write ports and dumped-item stream of banco_scanner.
// master = scanner side, slave = board debug logic together with banco.
interface banco_scanner_if #(
    parameter int size = 32
);
    logic            start;
    logic            mode;
    logic [4:0]      first_reg;
    logic [4:0]      last_reg;
    logic [size-1:0] fill_value;
    logic [4:0]      Read1;
    logic [size-1:0] Data1;
    logic [4:0]      WriteReg;
    logic [size-1:0] WriteData;
    logic            RegWrite;
    logic [size-1:0] out_data;
    logic [4:0]      out_index;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;

    modport master (
        input  start, mode, first_reg, last_reg, fill_value, Data1, out_ready,
        output Read1, WriteReg, WriteData, RegWrite, out_data, out_index,
               out_valid, busy, done
    );

    modport slave (
        output start, mode, first_reg, last_reg, fill_value, Data1, out_ready,
        input  Read1, WriteReg, WriteData, RegWrite, out_data, out_index,
               out_valid, busy, done
    );
endinterface

// File: rtl/banco_scanner.sv
// Walks a register range of banco: dump (2 cycles/reg, SEND stalls on out_ready) or fill (1 cycle/reg).
// All outputs registered; start is only seen in IDLE, done pulses one cycle at job end.
module banco_scanner #(
    parameter int size = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    banco_scanner_if.master   bus
);
    typedef enum logic [2:0] {IDLE, READ, SEND, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cur_q, cur_d;
    logic [4:0]      last_q, last_d;
    logic [size-1:0] fill_q, fill_d;
    logic [size-1:0] out_data_q, out_data_d;
    logic [4:0]      out_index_q, out_index_d;
    logic            out_valid_q, out_valid_d;
    logic            reg_write_q, reg_write_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        reg_write_d = reg_write_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    cur_d  = bus.first_reg;
                    last_d = bus.last_reg;
                    fill_d = bus.fill_value;
                    busy_d = 1'b1;
                    if (bus.mode) begin
                        state_d     = WRITE;
                        reg_write_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                out_data_d  = bus.Data1;
                out_index_d = cur_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d   = cur_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                // banco commits WriteReg=cur at this edge; the 5-bit add wraps 31 to 0
                if (cur_q == last_q) begin
                    reg_write_d = 1'b0;
                    state_d     = DONE;
                    done_d      = 1'b1;
                end else begin
                    cur_d = cur_q + 5'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Read1     = cur_q;
    assign bus.WriteReg  = cur_q;
    assign bus.WriteData = fill_q;
    assign bus.RegWrite  = reg_write_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
